hyper_mvblck_lsab2dram: RTL and testbench
=========================================

Name: hyper_mvblck_lsab2dram

Overview:
- Block mover directly downstream of hyper_lsab_dram; executes one block command per ISSUE pulse.
- Pops up to COUNT_REQ 32-bit words from one LSAB section and writes them to consecutive DRAM columns of the currently aligned page.
- Terminates early when the section runs dry.
- Reports words actually written (COUNT_SENT) and a WORKING level whose falling edge marks completion to the command stage.

Parameters:
- DW, 32, data word width.
- COLW, 12, column/byte-offset width within a DRAM page.
- CNTW, 6, block count width (max 63 words per command).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-low reset.
- ISSUE  in  1  one-cycle command strobe.
- START  in  COLW  first column; sampled with ISSUE.
- COUNT_REQ  in  CNTW  words requested; sampled with ISSUE.
- SECTION  in  2  LSAB section; sampled with ISSUE.
- COUNT_SENT  out  CNTW  words written by the last command.
- WORKING  out  1  high while a command is in progress.
- LSAB_SECTION  out  2  section select to the LSAB.
- LSAB_READ  out  1  pop strobe; one word per cycle.
- LSAB_EMPTY  in  1  selected section empty; combinational on LSAB_SECTION.
- LSAB_DATA  in  DW  popped word, valid exactly 1 cycle after LSAB_READ.
- MCU_VALID  out  1  column write request.
- MCU_READY  in  1  MCU accepts the request this cycle.
- MCU_COL  out  COLW  column address.
- MCU_WDATA  out  DW  write data.

Behaviour:
- Reset values: COUNT_SENT=0, WORKING=0, LSAB_READ=0, LSAB_SECTION=0, MCU_VALID=0, MCU_COL=0, MCU_WDATA=0. State=IDLE; holding buffer empty; in-flight flag clear.
- States: IDLE, RUN, FINISH.
- IDLE:
  - ISSUE=1 latches START, COUNT_REQ and SECTION, and clears the internal sent/requested counters.
  - Next cycle: WORKING=1, LSAB_SECTION=SECTION, state=RUN.
  - COUNT_SENT keeps its old value until the latch cycle, then counts up from 0.
- ISSUE outside IDLE is ignored. No queueing, no error flag.
- RUN, read side:
  - LSAB_READ=1 when requested<COUNT_REQ, LSAB_EMPTY=0, and (buffer occupancy + in-flight) < 2.
  - requested increments on each read.
  - A word arrives the next cycle and is pushed into a 2-entry FIFO holding buffer.
- RUN, write side:
  - MCU_VALID=1 whenever the buffer is non-empty; MCU_WDATA = buffer head; MCU_COL = START_latched + sent, modulo 2^COLW.
  - On MCU_VALID && MCU_READY: pop the buffer and increment sent and COUNT_SENT together.
  - MCU_VALID/MCU_COL/MCU_WDATA must hold stable while READY=0.
  - Sustained throughput: 1 word/cycle with READY=1 and LSAB non-empty.
- RUN exit to FINISH, when either holds:
  - sent==COUNT_REQ; or
  - early termination: requested<COUNT_REQ, LSAB_EMPTY=1, no read in flight, buffer empty.
- FINISH: WORKING=0 for one cycle, then IDLE.
  - COUNT_SENT is final from the first cycle WORKING is low and is held until the next accepted ISSUE.
  - The command stage samples it the cycle after its registered WORKING copy falls.
- COUNT_REQ=0: RUN exits in its first cycle. WORKING is high exactly 1 cycle; COUNT_SENT=0; no LSAB or MCU activity.
- Minimum WORKING high time is 1 cycle; the upstream edge detector depends on this.
- Column wrap past 2^COLW-1 wraps to 0. The command stage clips blocks at page end, so this does not occur in normal use.
- LSAB_EMPTY rising mid-block with words still buffered: the buffered words drain to the MCU, then early termination.
- Reset mid-operation: all state returns to reset values the next cycle. Buffered words are discarded.

Decomposition:
- Shared package (hyper_fabric_pkg): DW, COLW, CNTW; state encoding for IDLE/RUN/FINISH.
- One sub-module, hyper_skid2, implements the 2-entry holding FIFO:
  - ports: push, din, pop, dout, count[1:0];
  - simultaneous push and pop is allowed when full.
- Top level holds the FSM, counters and address adder.

Test Plan:
- Full block: START=0x100, COUNT_REQ=8, section 2 holding 8 words, READY=1.
  - Expect MCU_COL 0x100..0x107 with data in LSAB order, 8 consecutive cycles of MCU_VALID.
  - COUNT_SENT=8 when WORKING falls; WORKING low after ≈10 cycles.
- Early termination: COUNT_REQ=20, section holds 5 words.
  - Expect exactly 5 MCU writes (cols START..START+4), COUNT_SENT=5, WORKING falls.
  - LSAB_READ asserted exactly 5 times.
- Backpressure: COUNT_REQ=6; READY toggles 1,0,0,1,… (pattern fixed).
  - Expect no lost or duplicated words; VALID/COL/WDATA stable during READY=0.
  - Buffer never exceeds 2; LSAB_READ stalls when full.
- Zero count: ISSUE with COUNT_REQ=0.
  - WORKING high exactly 1 cycle; COUNT_SENT=0; no LSAB_READ or MCU_VALID.
- Overlapping ISSUE: second ISSUE (START=0x200) while RUN on a 4-word block.
  - Second ISSUE ignored; only cols of the first block written; COUNT_SENT=4.
- Reset mid-block: drop RST after 3 of 10 words written.
  - Next cycle all outputs at reset values (WORKING=0, COUNT_SENT=0).
  - A subsequent ISSUE with COUNT_REQ=2 completes normally.

Source files
------------

// File: rtl/hyper_fabric_pkg.sv
// Shared widths and state encoding for the LSAB-to-DRAM block mover.
package hyper_fabric_pkg;

  localparam int DW   = 32;  // data word width
  localparam int COLW = 12;  // column / byte offset within a DRAM page
  localparam int CNTW = 6;   // block word count (max 63 words per command)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } mv_state_e;

endpackage

// File: rtl/hyper_skid2.sv
// Two-entry holding FIFO between the LSAB pop pipeline and the MCU write port.
// A push while full is accepted only when a pop happens in the same cycle.
module hyper_skid2 #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [1:0]    count
);

  logic [DW-1:0] r_mem [2];
  logic          r_rd;
  logic          r_wr;
  logic [1:0]    r_count;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  // Storage, pointers and occupancy; reset discards any held words.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= din;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd];
  assign count = r_count;

endmodule

// File: rtl/hyper_mvblck_lsab2dram.sv
// Block mover: pops up to COUNT_REQ words from one LSAB section and writes
// them to consecutive DRAM columns, stopping early if the section runs dry.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for ISSUE; COUNT_SENT holds last command's result
//   ST_RUN    | popping LSAB into the holding FIFO, draining it to the MCU
//   ST_FINISH | WORKING low for one cycle before accepting a new command
module hyper_mvblck_lsab2dram
  import hyper_fabric_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            ISSUE,
  input  logic [COLW-1:0] START,
  input  logic [CNTW-1:0] COUNT_REQ,
  input  logic [1:0]      SECTION,
  output logic [CNTW-1:0] COUNT_SENT,
  output logic            WORKING,
  output logic [1:0]      LSAB_SECTION,
  output logic            LSAB_READ,
  input  logic            LSAB_EMPTY,
  input  logic [DW-1:0]   LSAB_DATA,
  output logic            MCU_VALID,
  input  logic            MCU_READY,
  output logic [COLW-1:0] MCU_COL,
  output logic [DW-1:0]   MCU_WDATA
);

  mv_state_e       r_state;
  logic [COLW-1:0] r_start;
  logic [CNTW-1:0] r_count_req;
  logic [CNTW-1:0] r_req;
  logic [CNTW-1:0] r_sent;
  logic [CNTW-1:0] r_count_sent;
  logic [1:0]      r_section;
  logic            r_working;
  logic            r_inflight;

  logic [1:0]      w_count;
  logic [DW-1:0]   w_head;
  logic            w_valid;
  logic            w_pop;
  logic [2:0]      w_occ;
  logic            w_read;
  logic            w_done;

  assign w_valid = (w_count != 2'd0);
  assign w_pop   = w_valid && MCU_READY;

  // Slots the FIFO will have committed once the in-flight word lands and this
  // cycle's pop retires. Counting the pop keeps reads flowing at one word per
  // cycle with a ready MCU; a new read's word lands next cycle, where the FIFO
  // accepts push-with-pop even when full.
  assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign w_read = (r_state == ST_RUN) && (r_req < r_count_req) &&
                  !LSAB_EMPTY && (w_occ < 3'd2);

  // Done when every requested word is written, or when the section is dry and
  // nothing remains in the read pipeline or the FIFO.
  assign w_done = (r_sent == r_count_req) ||
                  ((r_req < r_count_req) && LSAB_EMPTY && !r_inflight && !w_valid);

  hyper_skid2 #(
    .DW (DW)
  ) u_skid (
    .CLK   (CLK),
    .RST   (RST),
    .push  (r_inflight),
    .din   (LSAB_DATA),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count)
  );

  // Command FSM with latched parameters and the requested/sent counters.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_start      <= '0;
      r_count_req  <= '0;
      r_section    <= 2'd0;
      r_req        <= '0;
      r_sent       <= '0;
      r_count_sent <= '0;
      r_working    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ISSUE) begin
            r_start      <= START;
            r_count_req  <= COUNT_REQ;
            r_section    <= SECTION;
            r_req        <= '0;
            r_sent       <= '0;
            r_count_sent <= '0;
            r_working    <= 1'b1;
            r_state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_read) begin
            r_req <= r_req + CNTW'(1);
          end
          if (w_pop) begin
            r_sent       <= r_sent + CNTW'(1);
            r_count_sent <= r_count_sent + CNTW'(1);
          end
          if (w_done) begin
            r_working <= 1'b0;
            r_state   <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Tracks the LSAB one-cycle read latency; the returning word is pushed.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_read;
    end
  end

  assign COUNT_SENT   = r_count_sent;
  assign WORKING      = r_working;
  assign LSAB_SECTION = r_section;
  assign LSAB_READ    = w_read;
  assign MCU_VALID    = w_valid;
  assign MCU_COL      = r_start + COLW'(r_sent);
  assign MCU_WDATA    = w_head;

endmodule

// File: tb/tb_hyper_mvblck_lsab2dram.sv
// Directed bench for the LSAB-to-DRAM block mover with an LSAB model and an
// MCU write monitor.
`timescale 1ns/1ps
module tb_hyper_mvblck_lsab2dram;
  import hyper_fabric_pkg::*;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            ISSUE = 1'b0;
  logic [COLW-1:0] START = '0;
  logic [CNTW-1:0] COUNT_REQ = '0;
  logic [1:0]      SECTION = 2'd0;
  logic [CNTW-1:0] COUNT_SENT;
  logic            WORKING;
  logic [1:0]      LSAB_SECTION;
  logic            LSAB_READ;
  logic            LSAB_EMPTY;
  logic [DW-1:0]   LSAB_DATA = '0;
  logic            MCU_VALID;
  logic            MCU_READY;
  logic [COLW-1:0] MCU_COL;
  logic [DW-1:0]   MCU_WDATA;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  hyper_mvblck_lsab2dram u_dut (
    .CLK          (CLK),
    .RST          (RST),
    .ISSUE        (ISSUE),
    .START        (START),
    .COUNT_REQ    (COUNT_REQ),
    .SECTION      (SECTION),
    .COUNT_SENT   (COUNT_SENT),
    .WORKING      (WORKING),
    .LSAB_SECTION (LSAB_SECTION),
    .LSAB_READ    (LSAB_READ),
    .LSAB_EMPTY   (LSAB_EMPTY),
    .LSAB_DATA    (LSAB_DATA),
    .MCU_VALID    (MCU_VALID),
    .MCU_READY    (MCU_READY),
    .MCU_COL      (MCU_COL),
    .MCU_WDATA    (MCU_WDATA)
  );

  // MCU ready: fixed level, or the repeating 1,0,0 backpressure pattern
  logic rdy_mode  = 1'b0;
  logic rdy_fixed = 1'b1;
  int   rdy_phase = 0;
  assign MCU_READY = rdy_mode ? (rdy_phase == 0) : rdy_fixed;
  always @(posedge CLK) rdy_phase <= (rdy_phase == 2) ? 0 : rdy_phase + 1;

  // LSAB model: one loaded section, data returned one cycle after the pop
  logic [DW-1:0] lsab_data [64];
  int            lsab_n   = 0;
  int            lsab_rd  = 0;
  logic [1:0]    lsab_sec = 2'd0;
  logic          lsab_clr = 1'b0;
  assign LSAB_EMPTY = (LSAB_SECTION != lsab_sec) || (lsab_rd >= lsab_n);
  always @(posedge CLK) begin
    if (lsab_clr) lsab_rd <= 0;
    else if (LSAB_READ && !LSAB_EMPTY) begin
      LSAB_DATA <= lsab_data[lsab_rd];
      lsab_rd   <= lsab_rd + 1;
    end
  end

  // Monitor: accepted writes, pops, WORKING time, stall stability, FIFO depth
  logic            mon_clr = 1'b0;
  logic [COLW-1:0] wr_col [64];
  logic [DW-1:0]   wr_dat [64];
  int              wr_n = 0, rd_n = 0, work_hi = 0, val_n = 0, vrise = 0;
  int              stab_bad = 0, full_rd_bad = 0;
  logic [1:0]      max_occ = 2'd0;
  logic            prev_stall = 1'b0, p_valid = 1'b0;
  logic [COLW-1:0] p_col = '0;
  logic [DW-1:0]   p_dat = '0;
  always @(negedge CLK) begin
    if (mon_clr) begin
      wr_n <= 0; rd_n <= 0; work_hi <= 0; val_n <= 0; vrise <= 0;
      stab_bad <= 0; full_rd_bad <= 0; max_occ <= 2'd0;
      prev_stall <= 1'b0; p_valid <= 1'b0;
    end else begin
      if (MCU_VALID && MCU_READY && wr_n < 64) begin
        wr_col[wr_n] <= MCU_COL;
        wr_dat[wr_n] <= MCU_WDATA;
        wr_n <= wr_n + 1;
      end
      if (LSAB_READ) rd_n <= rd_n + 1;
      if (WORKING) work_hi <= work_hi + 1;
      if (MCU_VALID) val_n <= val_n + 1;
      if (MCU_VALID && !p_valid) vrise <= vrise + 1;
      if (prev_stall && (!MCU_VALID || MCU_COL != p_col || MCU_WDATA != p_dat))
        stab_bad <= stab_bad + 1;
      if (u_dut.w_count == 2'd2 && !(MCU_VALID && MCU_READY) && LSAB_READ)
        full_rd_bad <= full_rd_bad + 1;
      if (u_dut.w_count > max_occ) max_occ <= u_dut.w_count;
      prev_stall <= MCU_VALID && !MCU_READY;
      p_valid <= MCU_VALID;
      p_col <= MCU_COL;
      p_dat <= MCU_WDATA;
    end
  end

  task automatic load_lsab(input logic [1:0] sec, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) lsab_data[i] = base + DW'(i);
    lsab_n = n;
    lsab_sec = sec;
    lsab_clr = 1'b1;
    mon_clr = 1'b1;
    @(posedge CLK); #1;
    lsab_clr = 1'b0;
    @(negedge CLK); #1;
    mon_clr = 1'b0;
  endtask

  task automatic do_issue(input logic [COLW-1:0] s, input logic [CNTW-1:0] n, input logic [1:0] sec);
    @(posedge CLK); #1;
    ISSUE = 1'b1; START = s; COUNT_REQ = n; SECTION = sec;
    @(posedge CLK); #1;
    ISSUE = 1'b0;
  endtask

  task automatic wait_fall(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (!WORKING) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (COUNT_SENT !== 6'd0) $display("FAIL rst_count_sent: got %0d want 0", COUNT_SENT); else passed++;
    checks++; if (WORKING !== 1'b0) $display("FAIL rst_working: got %b want 0", WORKING); else passed++;
    checks++; if (LSAB_READ !== 1'b0) $display("FAIL rst_lsab_read: got %b want 0", LSAB_READ); else passed++;
    checks++; if (LSAB_SECTION !== 2'd0) $display("FAIL rst_section: got %0d want 0", LSAB_SECTION); else passed++;
    checks++; if (MCU_VALID !== 1'b0) $display("FAIL rst_mcu_valid: got %b want 0", MCU_VALID); else passed++;
    checks++; if (MCU_COL !== 12'h000) $display("FAIL rst_mcu_col: got %h want 000", MCU_COL); else passed++;
    checks++; if (MCU_WDATA !== 32'h0) $display("FAIL rst_mcu_wdata: got %h want 0", MCU_WDATA); else passed++;
    RST = 1'b1;
  endtask

  task automatic test_full_block();
    bit ok;
    load_lsab(2'd2, 8, 32'hC0DE_0000);
    do_issue(12'h100, 6'd8, 2'd2);
    checks++; if (LSAB_SECTION !== 2'd2) $display("FAIL full_section: got %0d want 2", LSAB_SECTION); else passed++;
    wait_fall(ok);
    checks++; if (!ok) $display("FAIL full_timeout: WORKING still %b want 0", WORKING); else passed++;
    checks++; if (COUNT_SENT !== 6'd8) $display("FAIL full_count_sent: got %0d want 8", COUNT_SENT); else passed++;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (wr_n != 8) $display("FAIL full_writes: got %0d want 8", wr_n); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++; if (wr_col[i] !== 12'h100 + COLW'(i)) $display("FAIL full_col[%0d]: got %h want %h", i, wr_col[i], 12'h100 + COLW'(i)); else passed++;
      checks++; if (wr_dat[i] !== 32'hC0DE_0000 + DW'(i)) $display("FAIL full_data[%0d]: got %h want %h", i, wr_dat[i], 32'hC0DE_0000 + DW'(i)); else passed++;
    end
    checks++; if (val_n != 8 || vrise != 1) $display("FAIL full_valid_run: got %0d cycles in %0d runs want 8 in 1", val_n, vrise); else passed++;
    checks++; if (work_hi != 11) $display("FAIL full_working_cycles: got %0d want 11", work_hi); else passed++;
    checks++; if (rd_n != 8) $display("FAIL full_reads: got %0d want 8", rd_n); else passed++;
  endtask

  task automatic test_early_term();
    bit ok;
    load_lsab(2'd1, 5, 32'h5EC1_0A00);
    do_issue(12'h040, 6'd20, 2'd1);
    wait_fall(ok);
    checks++; if (!ok) $display("FAIL early_timeout: WORKING still %b want 0", WORKING); else passed++;
    checks++; if (COUNT_SENT !== 6'd5) $display("FAIL early_count_sent: got %0d want 5", COUNT_SENT); else passed++;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (wr_n != 5) $display("FAIL early_writes: got %0d want 5", wr_n); else passed++;
    checks++; if (rd_n != 5) $display("FAIL early_reads: got %0d want 5", rd_n); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++; if (wr_col[i] !== 12'h040 + COLW'(i) || wr_dat[i] !== 32'h5EC1_0A00 + DW'(i))
        $display("FAIL early_write[%0d]: got col %h data %h want col %h data %h", i, wr_col[i], wr_dat[i], 12'h040 + COLW'(i), 32'h5EC1_0A00 + DW'(i));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [COLW-1:0] ecol;
    load_lsab(2'd3, 6, 32'hBEEF_0010);
    rdy_mode = 1'b1;
    do_issue(12'hFFD, 6'd6, 2'd3);
    wait_fall(ok);
    checks++; if (!ok) $display("FAIL bp_timeout: WORKING still %b want 0", WORKING); else passed++;
    checks++; if (COUNT_SENT !== 6'd6) $display("FAIL bp_count_sent: got %0d want 6", COUNT_SENT); else passed++;
    repeat (2) @(negedge CLK);
    #1;
    rdy_mode = 1'b0;
    checks++; if (wr_n != 6) $display("FAIL bp_writes: got %0d want 6", wr_n); else passed++;
    checks++; if (rd_n != 6) $display("FAIL bp_reads: got %0d want 6", rd_n); else passed++;
    for (int i = 0; i < 6; i++) begin
      ecol = 12'hFFD + COLW'(i);
      checks++; if (wr_col[i] !== ecol || wr_dat[i] !== 32'hBEEF_0010 + DW'(i))
        $display("FAIL bp_write[%0d]: got col %h data %h want col %h data %h", i, wr_col[i], wr_dat[i], ecol, 32'hBEEF_0010 + DW'(i));
      else passed++;
    end
    checks++; if (stab_bad != 0) $display("FAIL bp_stable: got %0d unstable stall cycles want 0", stab_bad); else passed++;
    checks++; if (max_occ != 2'd2) $display("FAIL bp_max_occ: got %0d want 2", max_occ); else passed++;
    checks++; if (full_rd_bad != 0) $display("FAIL bp_read_when_full: got %0d want 0", full_rd_bad); else passed++;
  endtask

  task automatic test_zero_count();
    bit ok;
    load_lsab(2'd0, 4, 32'h0000_0F00);
    do_issue(12'h010, 6'd0, 2'd0);
    wait_fall(ok);
    checks++; if (!ok) $display("FAIL zero_timeout: WORKING still %b want 0", WORKING); else passed++;
    checks++; if (COUNT_SENT !== 6'd0) $display("FAIL zero_count_sent: got %0d want 0", COUNT_SENT); else passed++;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (work_hi != 1) $display("FAIL zero_working_cycles: got %0d want 1", work_hi); else passed++;
    checks++; if (rd_n != 0 || val_n != 0) $display("FAIL zero_activity: got %0d reads %0d valid want 0 0", rd_n, val_n); else passed++;
  endtask

  task automatic test_overlap();
    bit ok;
    load_lsab(2'd2, 4, 32'h0A0A_0000);
    do_issue(12'h080, 6'd4, 2'd2);
    @(posedge CLK); #1;
    ISSUE = 1'b1; START = 12'h200; COUNT_REQ = 6'd9; SECTION = 2'd1;
    @(posedge CLK); #1;
    ISSUE = 1'b0;
    wait_fall(ok);
    checks++; if (!ok) $display("FAIL ovl_timeout: WORKING still %b want 0", WORKING); else passed++;
    checks++; if (COUNT_SENT !== 6'd4) $display("FAIL ovl_count_sent: got %0d want 4", COUNT_SENT); else passed++;
    repeat (6) @(negedge CLK);
    #1;
    checks++; if (WORKING !== 1'b0 || wr_n != 4) $display("FAIL ovl_ignored: got working %b writes %0d want 0 4", WORKING, wr_n); else passed++;
    checks++; if (LSAB_SECTION !== 2'd2) $display("FAIL ovl_section: got %0d want 2", LSAB_SECTION); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_col[i] !== 12'h080 + COLW'(i) || wr_dat[i] !== 32'h0A0A_0000 + DW'(i))
        $display("FAIL ovl_write[%0d]: got col %h data %h want col %h data %h", i, wr_col[i], wr_dat[i], 12'h080 + COLW'(i), 32'h0A0A_0000 + DW'(i));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    load_lsab(2'd0, 10, 32'h7700_0000);
    do_issue(12'h300, 6'd10, 2'd0);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (wr_n >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) $display("FAIL rmid_timeout: got %0d writes want 3", wr_n); else passed++;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (WORKING !== 1'b0 || COUNT_SENT !== 6'd0) $display("FAIL rmid_status: got working %b sent %0d want 0 0", WORKING, COUNT_SENT); else passed++;
    checks++; if (MCU_VALID !== 1'b0 || MCU_COL !== 12'h000 || MCU_WDATA !== 32'h0)
      $display("FAIL rmid_mcu: got valid %b col %h data %h want 0 000 0", MCU_VALID, MCU_COL, MCU_WDATA);
    else passed++;
    checks++; if (LSAB_READ !== 1'b0 || LSAB_SECTION !== 2'd0) $display("FAIL rmid_lsab: got read %b section %0d want 0 0", LSAB_READ, LSAB_SECTION); else passed++;
    RST = 1'b1;
    load_lsab(2'd1, 2, 32'h2222_0000);
    do_issue(12'h010, 6'd2, 2'd1);
    wait_fall(ok);
    checks++; if (!ok) $display("FAIL rmid_after_timeout: WORKING still %b want 0", WORKING); else passed++;
    checks++; if (COUNT_SENT !== 6'd2) $display("FAIL rmid_after_count: got %0d want 2", COUNT_SENT); else passed++;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (wr_n != 2) $display("FAIL rmid_after_writes: got %0d want 2", wr_n); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++; if (wr_col[i] !== 12'h010 + COLW'(i) || wr_dat[i] !== 32'h2222_0000 + DW'(i))
        $display("FAIL rmid_write[%0d]: got col %h data %h want col %h data %h", i, wr_col[i], wr_dat[i], 12'h010 + COLW'(i), 32'h2222_0000 + DW'(i));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_early_term();
    test_backpressure();
    test_zero_count();
    test_overlap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
